// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: shared constants and the {pc,instr} entry type for the fetch front end
package fetch_prefetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush; the head is read straight out of registered storage
module fetch_queue #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_pop;
    assign do_pop = pop && count != '0;
    assign head = count != '0 ? mem[rd] : '0;
    always_ff @(posedge clk)
        if (push) mem[wr] <= din;
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            rd <= rd + AW'(do_pop);
            wr <= wr + AW'(push);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: owns the PC, issues credit-limited word fetches and queues {pc,instr} for the core
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0] pc, fetch_pc;
    logic [CW-1:0] count, inflight, discard;
    logic fire, drop, accept;
    fetch_entry_t head;
    assign imem_req = rst && !redirect && (int'(count) + int'(inflight) < DEPTH);
    assign imem_addr = pc;
    assign fire = imem_req && imem_gnt;
    assign drop = imem_rvalid && (redirect || discard != '0);
    assign accept = imem_rvalid && !drop && inflight != '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
            discard <= '0;
        end else if (redirect) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
            // a response landing in the redirect cycle belongs to the work being abandoned
            discard <= discard + inflight - CW'(imem_rvalid && (discard != '0 || inflight != '0));
        end else begin
            if (fire) pc <= pc + 32'd4;
            if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
        end
    end
    always_ff @(posedge clk)
        if (rst && imem_rvalid) assert (inflight != '0 || discard != '0);
    fetch_queue #(.W(XLEN), .DEPTH(DEPTH)) u_pcq (
        .clk(clk), .rst(rst), .flush(redirect), .push(fire), .pop(accept),
        .din(pc), .head(fetch_pc), .count(inflight)
    );
    fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_outq (
        .clk(clk), .rst(rst), .flush(redirect), .push(accept), .pop(out_valid && out_ready),
        .din({fetch_pc, imem_rdata}), .head(head), .count(count)
    );
    assign out_valid = count != '0;
    assign out_pc = head.pc;
    assign out_instr = head.instr;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed + soak bench with an in-order memory model and a PC-stream scoreboard
module tb_fetch_prefetch_unit;
    import fetch_prefetch_unit_pkg::*;
    logic clk = 1'b0;
    logic rst, imem_req, imem_gnt, imem_rvalid, redirect, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    int pass_cnt = 0, total = 0;
    int lat = 1, cyc = 0, gnt_cnt = 0, outs = 0;
    bit rand_mem = 0;
    logic [31:0] pend_addr[$];
    int pend_due[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next = 32'h0;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    // memory: in-order responses, fixed minimum latency, optional random gnt/rvalid stalls
    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            imem_rvalid = 0;
            imem_rdata = 0;
            if (!rst) begin
                pend_addr.delete();
                pend_due.delete();
                imem_gnt = 0;
            end else begin
                imem_gnt = rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (pend_addr.size() > 0 && pend_due[0] <= cyc && (!rand_mem || $urandom_range(0, 2) != 0)) begin
                    imem_rvalid = 1;
                    imem_rdata = mem_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (imem_req && imem_gnt) begin
                    pend_addr.push_back(imem_addr);
                    pend_due.push_back(cyc + lat);
                    gnt_cnt++;
                end
            end
        end
    end

    // scoreboard: reset/redirect restart the expected PC stream; every handshake pops one entry
    initial forever begin
        logic [31:0] e;
        @(negedge clk); #2;
        if (!rst) begin
            exp_q.delete();
            exp_next = 32'h0;
        end else begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("stream_pc", out_pc, e);
                check("stream_instr", out_instr, mem_word(e));
                outs++;
            end
            if (redirect) begin
                exp_q.delete();
                exp_next = {redirect_pc[31:2], 2'b00};
            end
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next += 32'd4;
        end
    end

    initial begin
        int g0, o0, cool;
        rst = 0; redirect = 0; redirect_pc = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_imem_req", 32'(imem_req), 0);
        // 1: first fetch and latency
        @(negedge clk); rst = 1; out_ready = 1;
        #2;
        check("t1_req", 32'(imem_req), 1);
        check("t1_addr", imem_addr, 32'h0);
        @(negedge clk); #2;
        check("t1_valid_c1", 32'(out_valid), 0);
        @(negedge clk); #2;
        check("t1_valid_c2", 32'(out_valid), 1);
        check("t1_pc_c2", out_pc, 32'h0);
        @(negedge clk); #2;
        check("t1_pc_c3", out_pc, 32'h4);
        repeat (10) @(negedge clk);
        // 2: backpressure from empty fills exactly DEPTH credits
        rst = 0; out_ready = 0;
        @(negedge clk); rst = 1; g0 = gnt_cnt;
        repeat (10) @(negedge clk);
        #2;
        check("t2_gnts", 32'(gnt_cnt - g0), 4);
        check("t2_req_stall", 32'(imem_req), 0);
        check("t2_head", out_pc, 32'h0);
        @(negedge clk); out_ready = 1; o0 = outs;
        repeat (8) @(negedge clk);
        #2;
        check("t2_drained", 32'(outs - o0 >= 5), 1);
        // 3: redirect with three fetches in flight on a 3-cycle memory
        @(negedge clk); rst = 0; lat = 3;
        @(negedge clk); rst = 1;
        repeat (3) @(negedge clk);
        redirect = 1; redirect_pc = 32'h100;
        #2;
        check("t3_req_blocked", 32'(imem_req), 0);
        @(negedge clk); redirect = 0;
        #2;
        check("t3_valid_cleared", 32'(out_valid), 0);
        check("t3_addr", imem_addr, 32'h100);
        wait_valid("t3_valid");
        check("t3_pc", out_pc, 32'h100);
        check("t3_instr", out_instr, mem_word(32'h100));
        // 4: alignment, back-to-back redirects, address wrap
        @(negedge clk); lat = 1; redirect = 1; redirect_pc = 32'h203;
        @(negedge clk); redirect_pc = 32'hFFFF_FFFC;
        #2;
        check("t4_align", imem_addr, 32'h200);
        @(negedge clk); redirect = 0;
        #2;
        check("t4_last_wins", imem_addr, 32'hFFFF_FFFC);
        check("t4_req", 32'(imem_req), 1);
        @(negedge clk); #2;
        check("t4_wrap", imem_addr, 32'h0);
        wait_valid("t4_valid");
        check("t4_pc", out_pc, 32'hFFFF_FFFC);
        // 5: redirect coinciding with rvalid and pop
        repeat (6) @(negedge clk);
        redirect = 1; redirect_pc = 32'h400;
        #2;
        check("t5_pop_in_redirect", 32'(out_valid), 1);
        @(negedge clk); redirect = 0;
        #2;
        check("t5_valid_cleared", 32'(out_valid), 0);
        wait_valid("t5_valid");
        check("t5_pc", out_pc, 32'h400);
        // 6: reset mid-burst
        @(negedge clk); lat = 2;
        repeat (6) @(negedge clk);
        rst = 0;
        @(negedge clk); rst = 1;
        #2;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_pc", out_pc, 0);
        check("t6_instr", out_instr, 0);
        check("t6_addr", imem_addr, 32'h0);
        wait_valid("t6_restart");
        check("t6_first_pc", out_pc, 32'h0);
        // soak with random stalls, backpressure and spaced redirects
        rand_mem = 1; cool = 0; o0 = outs;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            out_ready = $urandom_range(0, 3) != 0;
            redirect = (cool == 0) && ($urandom_range(0, 49) == 0);
            redirect_pc = $urandom;
            cool = redirect ? 20 : (cool > 0 ? cool - 1 : 0);
            if (i % 1000 == 0) lat = $urandom_range(1, 3);
        end
        @(negedge clk); redirect = 0;
        #2;
        check("soak_progress", 32'(outs - o0 > 1000), 1);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
